// File: rtl/cfg_decoder.sv
// Configuration byte decoder: turns one DMA byte per write window into per-PE weight/opcode/route
// registers and START/END control. Optional rejected-byte counter: define CFG_DECODER_ERR_CNT_EN.
module cfg_decoder #(
  parameter int NUM_PE = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [7:0]            data_in,
  output logic [NUM_PE*6-1:0]   weight_flat,
  output logic [NUM_PE*4-1:0]   op_flat,
  output logic [NUM_PE*2-1:0]   next_flat,
  output logic [5:0]            operand,
  output logic                  start_pulse,
  output logic                  end_pulse,
  output logic                  busy,
  output logic [1:0]            pe_ptr
`ifdef CFG_DECODER_ERR_CNT_EN
  ,
  output logic [7:0]            err_cnt
`endif
);

  typedef enum logic {CFG = 1'b0, RUN = 1'b1} state_t;

  localparam logic [1:0] CMD_WEIGHT = 2'b00;
  localparam logic [1:0] CMD_LINK   = 2'b01;
  localparam logic [1:0] CMD_START  = 2'b10;
  localparam logic [1:0] CMD_END    = 2'b11;
  localparam logic [1:0] LAST_PE    = 2'(NUM_PE - 1);

  state_t      state_reg;
  logic        wr_en_reg;
  logic        accept;
  logic [1:0]  cmd;
  logic [5:0]  payload;
  logic        do_weight;
  logic        do_link;
  logic        do_start;
  logic        do_end;

  assign cmd     = data_in[7:6];
  assign payload = data_in[5:0];

  // A byte is taken only on the falling edge of the write window.
  assign accept    = wr_en_reg & ~wr_en;
  assign do_weight = accept && (state_reg == CFG) && (cmd == CMD_WEIGHT);
  assign do_link   = accept && (state_reg == CFG) && (cmd == CMD_LINK);
  assign do_start  = accept && (cmd == CMD_START);
  assign do_end    = accept && (state_reg == RUN) && (cmd == CMD_END);

  assign busy = (state_reg == RUN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= CFG;
      wr_en_reg   <= 1'b0;
      pe_ptr      <= 2'd0;
      operand     <= 6'd0;
      start_pulse <= 1'b0;
      end_pulse   <= 1'b0;
    end else begin
      wr_en_reg   <= wr_en;
      start_pulse <= do_start;
      end_pulse   <= do_end;
      if (do_link) begin
        pe_ptr <= (pe_ptr == LAST_PE) ? 2'd0 : pe_ptr + 2'd1;
      end
      if (do_start) begin
        operand   <= payload;
        state_reg <= RUN;
      end
      if (do_end) begin
        state_reg <= CFG;
        pe_ptr    <= 2'd0;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_pe
      localparam logic [1:0] PE_IDX = 2'(gi);
      logic [5:0] weight_reg;
      logic [3:0] op_reg;
      logic [1:0] next_reg;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          weight_reg <= 6'd0;
          op_reg     <= 4'd0;
          next_reg   <= 2'd0;
        end else if (pe_ptr == PE_IDX) begin
          if (do_weight) begin
            weight_reg <= payload;
          end
          if (do_link) begin
            next_reg <= payload[5:4];
            op_reg   <= payload[3:0];
          end
        end
      end

      assign weight_flat[gi*6 +: 6] = weight_reg;
      assign op_flat[gi*4 +: 4]     = op_reg;
      assign next_flat[gi*2 +: 2]   = next_reg;
    end
  endgenerate

`ifdef CFG_DECODER_ERR_CNT_EN
  logic reject;
  assign reject = accept & ~(do_weight | do_link | do_start | do_end);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_cnt <= 8'd0;
    end else if (reject && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cfg_decoder.sv
// Self-checking bench for cfg_decoder (NUM_PE = 4): table of bytes with expected outputs fed through
// a scoreboard queue, plus hand-written held-window and mid-window reset sequences.
module tb_cfg_decoder;

  typedef struct {
    logic [7:0]  data;
    logic [23:0] weight;
    logic [15:0] op;
    logic [7:0]  nxt;
    logic [5:0]  operand;
    logic        start;
    logic        endp;
    logic        busy;
    logic [1:0]  pe;
    logic [7:0]  err;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  data_in = 8'd0;
  logic [23:0] weight_flat;
  logic [15:0] op_flat;
  logic [7:0]  next_flat;
  logic [5:0]  operand;
  logic        start_pulse;
  logic        end_pulse;
  logic        busy;
  logic [1:0]  pe_ptr;
`ifdef CFG_DECODER_ERR_CNT_EN
  logic [7:0]  err_cnt;
`endif

  int   checks = 0;
  int   errors = 0;
  vec_t sb_q[$];
  vec_t vecs[16];
  vec_t zero_v;
  vec_t snap_v;

  cfg_decoder #(.NUM_PE(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .data_in     (data_in),
    .weight_flat (weight_flat),
    .op_flat     (op_flat),
    .next_flat   (next_flat),
    .operand     (operand),
    .start_pulse (start_pulse),
    .end_pulse   (end_pulse),
    .busy        (busy),
    .pe_ptr      (pe_ptr)
`ifdef CFG_DECODER_ERR_CNT_EN
    ,
    .err_cnt     (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [7:0] d, input logic [23:0] w, input logic [15:0] o,
                              input logic [7:0] n, input logic [5:0] opd, input logic s,
                              input logic e, input logic b, input logic [1:0] p, input logic [7:0] er);
    vec_t v;
    v.data = d; v.weight = w; v.op = o; v.nxt = n; v.operand = opd;
    v.start = s; v.endp = e; v.busy = b; v.pe = p; v.err = er;
    return v;
  endfunction

  task automatic compare(input string name, input vec_t e);
    logic bad;
    bad = (weight_flat !== e.weight) || (op_flat !== e.op) || (next_flat !== e.nxt) ||
          (operand !== e.operand) || (start_pulse !== e.start) || (end_pulse !== e.endp) ||
          (busy !== e.busy) || (pe_ptr !== e.pe);
`ifdef CFG_DECODER_ERR_CNT_EN
    bad = bad || (err_cnt !== e.err);
`endif
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s: got w=%h op=%h nx=%h opd=%h s=%b e=%b busy=%b pe=%0d; want w=%h op=%h nx=%h opd=%h s=%b e=%b busy=%b pe=%0d err=%0d",
               name, weight_flat, op_flat, next_flat, operand, start_pulse, end_pulse, busy, pe_ptr,
               e.weight, e.op, e.nxt, e.operand, e.start, e.endp, e.busy, e.pe, e.err);
    end
  endtask

  // One write window: wr_en rises with junk data, falls with the real byte.
  task automatic send(input int idx, input vec_t e);
    vec_t exp_v;
    @(negedge clk); wr_en = 1'b1; data_in = 8'($urandom);
    @(negedge clk); wr_en = 1'b0; data_in = e.data; sb_q.push_back(e);
    @(posedge clk); #1;
    exp_v = sb_q.pop_front();
    compare("table_vec", exp_v);
    $display("txn %0d data=%h w=%h op=%h nx=%h opd=%h s=%b e=%b busy=%b pe=%0d",
             idx, exp_v.data, weight_flat, op_flat, next_flat, operand, start_pulse, end_pulse, busy, pe_ptr);
    exp_v.start = 1'b0;
    exp_v.endp  = 1'b0;
    @(posedge clk); #1;
    compare("pulse_clear", exp_v);
  endtask

  initial begin
    zero_v = mk(8'h00, 24'h0, 16'h0, 8'h0, 6'h0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
    //             data   weight      op         next   opd    s     e     busy  pe    err
    vecs[0]  = mk(8'h2A, 24'h00002A, 16'h0000, 8'h00, 6'h00, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
    vecs[1]  = mk(8'h53, 24'h00002A, 16'h0003, 8'h01, 6'h00, 1'b0, 1'b0, 1'b0, 2'd1, 8'd0);
    vecs[2]  = mk(8'h65, 24'h00002A, 16'h0053, 8'h09, 6'h00, 1'b0, 1'b0, 1'b0, 2'd2, 8'd0);
    vecs[3]  = mk(8'h77, 24'h00002A, 16'h0753, 8'h39, 6'h00, 1'b0, 1'b0, 1'b0, 2'd3, 8'd0);
    vecs[4]  = mk(8'h41, 24'h00002A, 16'h1753, 8'h39, 6'h00, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
    vecs[5]  = mk(8'h85, 24'h00002A, 16'h1753, 8'h39, 6'h05, 1'b1, 1'b0, 1'b1, 2'd0, 8'd0);
    vecs[6]  = mk(8'h3F, 24'h00002A, 16'h1753, 8'h39, 6'h05, 1'b0, 1'b0, 1'b1, 2'd0, 8'd1);
    vecs[7]  = mk(8'h91, 24'h00002A, 16'h1753, 8'h39, 6'h11, 1'b1, 1'b0, 1'b1, 2'd0, 8'd1);
    vecs[8]  = mk(8'hC0, 24'h00002A, 16'h1753, 8'h39, 6'h11, 1'b0, 1'b1, 1'b0, 2'd0, 8'd1);
    vecs[9]  = mk(8'hC0, 24'h00002A, 16'h1753, 8'h39, 6'h11, 1'b0, 1'b0, 1'b0, 2'd0, 8'd2);
    vecs[10] = mk(8'h15, 24'h000015, 16'h1753, 8'h39, 6'h11, 1'b0, 1'b0, 1'b0, 2'd0, 8'd2);
    vecs[11] = mk(8'h7F, 24'h000015, 16'h175F, 8'h3B, 6'h11, 1'b0, 1'b0, 1'b0, 2'd1, 8'd2);
    vecs[12] = mk(8'h2C, 24'h000B15, 16'h175F, 8'h3B, 6'h11, 1'b0, 1'b0, 1'b0, 2'd1, 8'd2);
    vecs[13] = mk(8'h80, 24'h000B15, 16'h175F, 8'h3B, 6'h00, 1'b1, 1'b0, 1'b1, 2'd1, 8'd2);
    vecs[14] = mk(8'h55, 24'h000B15, 16'h175F, 8'h3B, 6'h00, 1'b0, 1'b0, 1'b1, 2'd1, 8'd3);
    vecs[15] = mk(8'hC0, 24'h000B15, 16'h175F, 8'h3B, 6'h00, 1'b0, 1'b1, 1'b0, 2'd0, 8'd3);

    repeat (3) @(posedge clk);
    #1 compare("reset_state", zero_v);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1 compare("after_release", zero_v);

    for (int i = 0; i < 16; i++) send(i, vecs[i]);

    // wr_en held high: nothing may be accepted whatever data_in does.
    snap_v = vecs[15];
    snap_v.endp = 1'b0;
    @(negedge clk); wr_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); data_in = 8'($urandom);
      @(posedge clk); #1 compare("hold_high", snap_v);
    end

    // Reset mid-window with a WEIGHT byte pending, then wr_en still high at release.
    @(negedge clk); data_in = 8'h2A;
    #2 reset = 1'b0;
    #1 compare("async_reset", zero_v);
    @(negedge clk); reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1 compare("release_hold", zero_v);
    end
    @(negedge clk); wr_en = 1'b0;
    @(posedge clk); #1 compare("first_fall", mk(8'h2A, 24'h00002A, 16'h0, 8'h0, 6'h0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0));
    $display("txn reset_window data=2a w=%h pe=%0d", weight_flat, pe_ptr);

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
